mem_responder: RTL

- Memory-side responder for the core's memory bus.
- It answers the bus requests that the core's arbiter issues: it samples each request, waits a configurable number of cycles, commits or reads 8-bit data, and returns a single-cycle ready.
- It holds the program/data store and has a side load port for boot images.
- It sits between the core top level and the bench or system memory map.

---
 rtl/mem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Memory-side bus responder: fixed-latency read/write to an 8-bit store plus a boot-load side port.
// Define MEM_RESPONDER_MMIO_EN to map address 8'hFF to the io_in/io_out register instead of memory.
module mem_responder #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [7:0] addr,
   input  logic       we,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       ready,
   output logic       busy,
   input  logic       load_we,
   input  logic [7:0] load_addr,
   input  logic [7:0] load_data,
   input  logic [7:0] io_in,
   output logic [7:0] io_out,
   output logic       io_strobe
);

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [8:0] DEPTH_W   = 9'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] addr_q, addr_d;
   logic       we_q, we_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] mem_q [DEPTH];

   logic       commit;
   logic [7:0] cur_addr;
   logic       cur_we;
   logic [7:0] cur_wdata;
   logic       cur_mmio;
   logic       mem_wr_en;
   logic       load_ok;

   function automatic logic in_range(input logic [7:0] a);
      return {1'b0, a} < DEPTH_W;
   endfunction

   // With zero wait the commit happens on the capture edge, so live bus inputs are used there.
   assign cur_addr  = (state_q == S_IDLE) ? addr  : addr_q;
   assign cur_we    = (state_q == S_IDLE) ? we    : we_q;
   assign cur_wdata = (state_q == S_IDLE) ? wdata : wdata_q;

`ifdef MEM_RESPONDER_MMIO_EN
   logic [7:0] io_out_q, io_out_d;
   logic       io_strobe_q, io_strobe_d;

   assign cur_mmio = (cur_addr == 8'hFF);
   assign load_ok  = load_we && in_range(load_addr) && (load_addr != 8'hFF);

   always_comb begin
      io_out_d    = io_out_q;
      io_strobe_d = 1'b0;
      if (commit && cur_we && cur_mmio) begin
         io_out_d    = cur_wdata;
         io_strobe_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io_out_q    <= 8'h00;
         io_strobe_q <= 1'b0;
      end else begin
         io_out_q    <= io_out_d;
         io_strobe_q <= io_strobe_d;
      end
   end

   assign io_out    = io_out_q;
   assign io_strobe = io_strobe_q;
`else
   logic unused_io;

   assign unused_io = ^io_in;
   assign cur_mmio  = 1'b0;
   assign load_ok   = load_we && in_range(load_addr);
   assign io_out    = 8'h00;
   assign io_strobe = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      commit  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               addr_d  = addr;
               we_d    = we;
               wdata_d = wdata;
               cnt_d   = WAIT_INIT;
               if (WAIT_INIT == 4'd0) begin
                  state_d = S_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (commit && !cur_we) begin
`ifdef MEM_RESPONDER_MMIO_EN
         if (cur_mmio) rdata_d = io_in;
         else
`endif
         if (in_range(cur_addr)) rdata_d = mem_q[cur_addr[AW-1:0]];
         else                    rdata_d = 8'h00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
   end

   // The load port is written last so it overrides a bus write to the same word.
   assign mem_wr_en = commit && cur_we && !cur_mmio && in_range(cur_addr) && !rst;

   always_ff @(posedge clk) begin
      if (mem_wr_en) mem_q[cur_addr[AW-1:0]]  <= cur_wdata;
      if (load_ok)   mem_q[load_addr[AW-1:0]] <= load_data;
   end

   assign rdata = rdata_q;
   assign ready = (state_q == S_RESP);
   assign busy  = (state_q != S_IDLE);

endmodule
